load_bin: RTL
=============

LOAD_BIN -- requirements
Module: load_bin
Interface
REQ-001 NUM_CLAUSES_A_BIN, 8, clause slots per bin.
REQ-002 NUM_VARS_A_BIN, 8, variable slots per bin.
REQ-003 NUM_LVLS_A_BIN, 8, level slots per bin.
REQ-004 WIDTH_CLAUSES, NUM_VARS_A_BIN*2, clause word width.
REQ-005 WIDTH_VARS, 12, global variable id width.
REQ-006 WIDTH_LVL, 16, decision level width.
REQ-007 WIDTH_BIN_ID, 10, bin number width.
REQ-008 WIDTH_STATES, 30, var-state and lvl-state word width.
REQ-009 ADDR_WIDTH, 9, address width of all four RAMs.
REQ-010 clk  in  1  single clock; all state on rising edge.
REQ-011 rst  in  1  reset, asynchronous, active-low.
REQ-012 start_load  in  1  one-cycle load request.
REQ-013 request_bin_num_i  in  WIDTH_BIN_ID  bin to load.
REQ-014 base_lvl_i  in  WIDTH_LVL  first level-state address of this bin.
REQ-015 busy_o  out  1  high while not IDLE.
REQ-016 done_load  out  1  one-cycle completion pulse.
REQ-017 ram_addr_c_o  out  ADDR_WIDTH  clause RAM read address.
REQ-018 ram_data_c_i  in  WIDTH_CLAUSES  clause RAM data, 1-cycle latency.
REQ-019 ram_addr_v_o  out  ADDR_WIDTH  var-bin RAM read address.
REQ-020 ram_data_v_i  in  WIDTH_VARS  global var id, 1-cycle latency.
REQ-021 ram_addr_v_state_o  out  ADDR_WIDTH  var-state RAM read address.
REQ-022 ram_data_v_state_i  in  WIDTH_STATES  var state, 1-cycle latency.
REQ-023 ram_addr_l_state_o  out  ADDR_WIDTH  lvl-state RAM read address.
REQ-024 ram_data_l_state_i  in  WIDTH_STATES  lvl state, 1-cycle latency.
REQ-025 wr_carray_o  out  NUM_CLAUSES_A_BIN  one-hot clause write strobe to SAT engine.
REQ-026 clause_o  out  WIDTH_CLAUSES  clause data to SAT engine.
REQ-027 wr_var_states_o  out  NUM_VARS_A_BIN  one-hot var-state write strobe.
REQ-028 var_state_o  out  WIDTH_STATES  var-state data.
REQ-029 wr_lvl_states_o  out  NUM_LVLS_A_BIN  one-hot lvl-state write strobe.
REQ-030 lvl_state_o  out  WIDTH_STATES  lvl-state data.
Function
REQ-031 FSM SHALL have states IDLE, LOAD_C, LOAD_V, LOAD_L, DONE; IDLE->LOAD_C on start_load; each LOAD_* lasts exactly N cycles (N = its slot count), then advances; DONE->IDLE after 1 cycle.
REQ-032 request_bin_num_i and base_lvl_i SHALL be captured on accepted start_load; start_load outside IDLE SHALL be ignored.
REQ-033 LOAD_C cycle k SHALL drive ram_addr_c_o = bin*NUM_CLAUSES_A_BIN + k; next cycle wr_carray_o = 1<<k with clause_o = ram_data_c_i.
REQ-034 LOAD_V cycle k SHALL drive ram_addr_v_o = bin*NUM_VARS_A_BIN + k; next cycle ram_addr_v_state_o = ram_data_v_i (truncated); following cycle wr_var_states_o = 1<<k, var_state_o = ram_data_v_state_i.
REQ-035 LOAD_L cycle k SHALL drive ram_addr_l_state_o = base_lvl_i + k; next cycle wr_lvl_states_o = 1<<k, lvl_state_o = ram_data_l_state_i.
REQ-036 Address sums SHALL be truncated modulo 2^ADDR_WIDTH (wrap, no saturation).
REQ-037 Timing from start_load at cycle 0: clause strobes cycles 2-9, var strobes 11-18, lvl strobes 18-25, DONE cycle 25, done_load high cycle 26 only; busy_o high cycles 1-25.
REQ-038 Strobe and data outputs SHALL be zero in every cycle without a strobe; at most one bit per strobe bus set.
REQ-039 Back-to-back start_load SHALL be accepted earliest in the cycle after returning to IDLE.
Reset
REQ-040 rst low SHALL immediately force IDLE and all outputs/counters/captured registers to 0, including mid-load; no further strobes after release until a new start_load.
Configuration
REQ-041 With LOAD_BIN_ZERO_EMPTY_VAR_EN defined, a slot whose ram_data_v_i is 0 SHALL emit var_state_o = 0 (strobe still issued); undefined, ram_data_v_state_i SHALL pass unmodified.
Verification
REQ-042 bin=3, clause RAM addr 24..31 = 0x1000+addr -> wr_carray_o 0x01..0x80 cycles 2-9, clause_o 0x1018..0x101F.
REQ-043 bin=2, var ids 5,0,7,... at addr 16..23 -> ram_addr_v_state_o 5,0,7 cycles 10-12; with macro, slot 1 var_state_o = 0.
REQ-044 base_lvl_i=510 -> ram_addr_l_state_o 510,511,0,1,...,5 (wrap).
REQ-045 start_load at cycle 0 and again cycle 5 -> second ignored; done_load only cycle 26.
REQ-046 rst low at cycle 12 -> all outputs 0 same cycle, busy_o 0, no done_load.

Source files
------------

// File: rtl/load_bin.sv
// load_bin: copies one bin of clauses, variable states and level states from
// four read RAMs (1-cycle latency) into the SAT engine's slot registers.
// The load runs as a fixed sequence LOAD_C -> LOAD_V -> LOAD_L -> DONE, and
// each write strobe is one-hot.
// Optional feature: define LOAD_BIN_ZERO_EMPTY_VAR_EN to force var_state_o to 0
// for slots whose global variable id is 0 (an empty slot).
module load_bin #(
    parameter int NUM_CLAUSES_A_BIN = 8,
    parameter int NUM_VARS_A_BIN    = 8,
    parameter int NUM_LVLS_A_BIN    = 8,
    parameter int WIDTH_CLAUSES     = NUM_VARS_A_BIN * 2,
    parameter int WIDTH_VARS        = 12,
    parameter int WIDTH_LVL         = 16,
    parameter int WIDTH_BIN_ID      = 10,
    parameter int WIDTH_STATES      = 30,
    parameter int ADDR_WIDTH        = 9
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start_load,
    input  logic [WIDTH_BIN_ID-1:0]      request_bin_num_i,
    input  logic [WIDTH_LVL-1:0]         base_lvl_i,
    output logic                         busy_o,
    output logic                         done_load,
    output logic [ADDR_WIDTH-1:0]        ram_addr_c_o,
    input  logic [WIDTH_CLAUSES-1:0]     ram_data_c_i,
    output logic [ADDR_WIDTH-1:0]        ram_addr_v_o,
    input  logic [WIDTH_VARS-1:0]        ram_data_v_i,
    output logic [ADDR_WIDTH-1:0]        ram_addr_v_state_o,
    input  logic [WIDTH_STATES-1:0]      ram_data_v_state_i,
    output logic [ADDR_WIDTH-1:0]        ram_addr_l_state_o,
    input  logic [WIDTH_STATES-1:0]      ram_data_l_state_i,
    output logic [NUM_CLAUSES_A_BIN-1:0] wr_carray_o,
    output logic [WIDTH_CLAUSES-1:0]     clause_o,
    output logic [NUM_VARS_A_BIN-1:0]    wr_var_states_o,
    output logic [WIDTH_STATES-1:0]      var_state_o,
    output logic [NUM_LVLS_A_BIN-1:0]    wr_lvl_states_o,
    output logic [WIDTH_STATES-1:0]      lvl_state_o
);

`ifdef LOAD_BIN_ZERO_EMPTY_VAR_EN
    localparam bit ZERO_EMPTY = 1'b1;
`else
    localparam bit ZERO_EMPTY = 1'b0;
`endif

    // Slot counter width; wide enough for any realistic bin size.
    localparam int CNT_W = 8;

    typedef enum logic [2:0] {IDLE, LOAD_C, LOAD_V, LOAD_L, DONE} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH_BIN_ID-1:0] bin_q, bin_d;
    logic [WIDTH_LVL-1:0]    base_q, base_d;
    // Pipeline tags that follow the RAM read latency: each stage carries a valid bit and the slot index.
    logic              c_vld_q, c_vld_d;
    logic [CNT_W-1:0]  c_idx_q, c_idx_d;
    logic              v1_vld_q, v1_vld_d;
    logic [CNT_W-1:0]  v1_idx_q, v1_idx_d;
    logic              v2_vld_q, v2_vld_d;
    logic [CNT_W-1:0]  v2_idx_q, v2_idx_d;
    logic              v2_zero_q, v2_zero_d;
    logic              l_vld_q, l_vld_d;
    logic [CNT_W-1:0]  l_idx_q, l_idx_d;
    logic              done_q, done_d;

    // Next-state, slot counter, request capture and pipeline tag advance.
    always_comb begin
        // NOTE: every signal gets a default first, so no path through the case can infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        bin_d     = bin_q;
        base_d    = base_q;
        c_vld_d   = 1'b0;
        c_idx_d   = cnt_q;
        v1_vld_d  = 1'b0;
        v1_idx_d  = cnt_q;
        v2_vld_d  = v1_vld_q;
        v2_idx_d  = v1_idx_q;
        v2_zero_d = v1_vld_q & ~|ram_data_v_i;
        l_vld_d   = 1'b0;
        l_idx_d   = cnt_q;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_load) begin
                    state_d = LOAD_C;
                    cnt_d   = '0;
                    bin_d   = request_bin_num_i;
                    base_d  = base_lvl_i;
                end
            end
            LOAD_C: begin
                c_vld_d = 1'b1;
                if (cnt_q == CNT_W'(NUM_CLAUSES_A_BIN - 1)) begin
                    cnt_d   = '0;
                    state_d = LOAD_V;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LOAD_V: begin
                v1_vld_d = 1'b1;
                if (cnt_q == CNT_W'(NUM_VARS_A_BIN - 1)) begin
                    cnt_d   = '0;
                    state_d = LOAD_L;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LOAD_L: begin
                l_vld_d = 1'b1;
                if (cnt_q == CNT_W'(NUM_LVLS_A_BIN - 1)) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset aborts any load in progress and clears every captured value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bin_q     <= '0;
            base_q    <= '0;
            c_vld_q   <= 1'b0;
            c_idx_q   <= '0;
            v1_vld_q  <= 1'b0;
            v1_idx_q  <= '0;
            v2_vld_q  <= 1'b0;
            v2_idx_q  <= '0;
            v2_zero_q <= 1'b0;
            l_vld_q   <= 1'b0;
            l_idx_q   <= '0;
            done_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every flop sample the pre-edge values of the others.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bin_q     <= bin_d;
            base_q    <= base_d;
            c_vld_q   <= c_vld_d;
            c_idx_q   <= c_idx_d;
            v1_vld_q  <= v1_vld_d;
            v1_idx_q  <= v1_idx_d;
            v2_vld_q  <= v2_vld_d;
            v2_idx_q  <= v2_idx_d;
            v2_zero_q <= v2_zero_d;
            l_vld_q   <= l_vld_d;
            l_idx_q   <= l_idx_d;
            done_q    <= done_d;
        end
    end

    // Outputs: addresses come from state and counter, strobes and data from the pipeline tags; all are zero when inactive.
    always_comb begin
        busy_o             = (state_q != IDLE);
        done_load          = done_q;
        ram_addr_c_o       = '0;
        ram_addr_v_o       = '0;
        ram_addr_v_state_o = '0;
        ram_addr_l_state_o = '0;
        wr_carray_o        = '0;
        clause_o           = '0;
        wr_var_states_o    = '0;
        var_state_o        = '0;
        wr_lvl_states_o    = '0;
        lvl_state_o        = '0;
        if (state_q == LOAD_C)
            ram_addr_c_o = ADDR_WIDTH'(int'(bin_q) * NUM_CLAUSES_A_BIN + int'(cnt_q));
        if (state_q == LOAD_V)
            ram_addr_v_o = ADDR_WIDTH'(int'(bin_q) * NUM_VARS_A_BIN + int'(cnt_q));
        if (state_q == LOAD_L)
            ram_addr_l_state_o = ADDR_WIDTH'(base_q + WIDTH_LVL'(cnt_q));
        if (c_vld_q) begin
            wr_carray_o = NUM_CLAUSES_A_BIN'(1) << c_idx_q;
            clause_o    = ram_data_c_i;
        end
        if (v1_vld_q)
            ram_addr_v_state_o = ram_data_v_i[ADDR_WIDTH-1:0];
        if (v2_vld_q) begin
            wr_var_states_o = NUM_VARS_A_BIN'(1) << v2_idx_q;
            var_state_o     = (ZERO_EMPTY && v2_zero_q) ? '0 : ram_data_v_state_i;
        end
        if (l_vld_q) begin
            wr_lvl_states_o = NUM_LVLS_A_BIN'(1) << l_idx_q;
            lvl_state_o     = ram_data_l_state_i;
        end
    end

endmodule
